// File: rtl/morra_pkg.sv
// Shared types and the move-dominance helper for the morra referee.
package morra_pkg;

    typedef enum logic [1:0] {
        MV_NONE     = 2'b00,
        MV_ROCK     = 2'b01,
        MV_PAPER    = 2'b10,
        MV_SCISSORS = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        OUT_VOID = 2'b00,
        OUT_P1   = 2'b01,
        OUT_P2   = 2'b10,
        OUT_DRAW = 2'b11
    } outcome_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DONE = 2'b10
    } state_t;

    // True when move a defeats move b (both must be real moves).
    function automatic logic beats(input move_t a, input move_t b);
        return ((a == MV_ROCK)     && (b == MV_SCISSORS)) ||
               ((a == MV_SCISSORS) && (b == MV_PAPER))    ||
               ((a == MV_PAPER)    && (b == MV_ROCK));
    endfunction

endpackage

// File: rtl/morra_judge.sv
// Combinational round judge: two moves plus repeat memory -> round outcome.
module morra_judge
    import morra_pkg::*;
#(
    parameter int unsigned NO_REPEAT = 1
) (
    input  logic [1:0] primo,
    input  logic [1:0] secondo,
    input  outcome_t   mem_winner,
    input  move_t      mem_move,
    output outcome_t   outcome,
    output move_t      win_move
);

    move_t    p1;
    move_t    p2;
    outcome_t raw;

    assign p1 = move_t'(primo);
    assign p2 = move_t'(secondo);

    // Raw judgement (forfeits included), then the winner-may-not-repeat veto.
    always_comb begin
        raw      = OUT_VOID;
        win_move = MV_NONE;
        if ((p1 == MV_NONE) && (p2 == MV_NONE)) begin
            raw = OUT_VOID;
        end else if (p1 == MV_NONE) begin
            raw      = OUT_P2;
            win_move = p2;
        end else if (p2 == MV_NONE) begin
            raw      = OUT_P1;
            win_move = p1;
        end else if (p1 == p2) begin
            raw = OUT_DRAW;
        end else if (beats(p1, p2)) begin
            raw      = OUT_P1;
            win_move = p1;
        end else begin
            raw      = OUT_P2;
            win_move = p2;
        end

        outcome = raw;
        // mem_winner is OUT_VOID when the memory is empty, so only a P1/P2 match can veto.
        if ((NO_REPEAT != 0) && ((raw == OUT_P1) || (raw == OUT_P2)) &&
            (raw == mem_winner) && (win_move == mem_move)) begin
            outcome = OUT_VOID;
        end
    end

endmodule

// File: rtl/morra_referee_param.sv
// Morra referee: match FSM, score counters, early-end check, registered outputs.
module morra_referee_param
    import morra_pkg::*;
#(
    parameter int unsigned CFG_W       = 4,
    parameter int unsigned BASE_ROUNDS = 4,
    parameter int unsigned CNT_W       = 5,
    parameter int unsigned MIN_ROUNDS  = 4,
    parameter int unsigned MARGIN      = 2,
    parameter int unsigned NO_REPEAT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             START,
    input  logic [CFG_W-1:0] CONFIG,
    input  logic             MOVE_VALID,
    input  logic [1:0]       PRIMO,
    input  logic [1:0]       SECONDO,
    output logic [1:0]       MANCHE,
    output logic             MANCHE_VALID,
    output logic [CNT_W-1:0] VINTE_PRIMO,
    output logic [CNT_W-1:0] VINTE_SECONDO,
    output logic [CNT_W-1:0] PAREGGI,
    output logic             BUSY,
    output logic             FINE_CONTO,
    output logic [1:0]       PARTITA
);

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] target_q,  target_d;
    logic [CNT_W-1:0] vp_q,      vp_d;
    logic [CNT_W-1:0] vs_q,      vs_d;
    logic [CNT_W-1:0] pa_q,      pa_d;
    outcome_t         manche_q,  manche_d;
    logic             mv_q,      mv_d;
    logic [1:0]       partita_q, partita_d;
    logic             fine_q,    fine_d;
    outcome_t         mem_win_q, mem_win_d;
    move_t            mem_mv_q,  mem_mv_d;

    outcome_t         judged;
    move_t            judged_move;
    logic             counted;
    logic [CNT_W+1:0] played_n;
    logic [CNT_W-1:0] diff_n;

    morra_judge #(
        .NO_REPEAT(NO_REPEAT)
    ) u_judge (
        .primo     (PRIMO),
        .secondo   (SECONDO),
        .mem_winner(mem_win_q),
        .mem_move  (mem_mv_q),
        .outcome   (judged),
        .win_move  (judged_move)
    );

    // Next-state, counter and output logic; START overrides any same-cycle move.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        vp_d      = vp_q;
        vs_d      = vs_q;
        pa_d      = pa_q;
        manche_d  = manche_q;
        mv_d      = 1'b0;
        partita_d = partita_q;
        fine_d    = fine_q;
        mem_win_d = mem_win_q;
        mem_mv_d  = mem_mv_q;
        counted   = 1'b0;

        if (START) begin
            state_d   = PLAY;
            target_d  = CNT_W'(CONFIG) + CNT_W'(BASE_ROUNDS);
            vp_d      = '0;
            vs_d      = '0;
            pa_d      = '0;
            manche_d  = OUT_VOID;
            partita_d = '0;
            fine_d    = 1'b0;
            mem_win_d = OUT_VOID;
            mem_mv_d  = MV_NONE;
        end else if ((state_q == PLAY) && MOVE_VALID) begin
            manche_d = judged;
            mv_d     = 1'b1;
            case (judged)
                OUT_P1: begin
                    vp_d      = vp_q + 1'b1;
                    mem_win_d = OUT_P1;
                    mem_mv_d  = judged_move;
                    counted   = 1'b1;
                end
                OUT_P2: begin
                    vs_d      = vs_q + 1'b1;
                    mem_win_d = OUT_P2;
                    mem_mv_d  = judged_move;
                    counted   = 1'b1;
                end
                OUT_DRAW: begin
                    pa_d      = pa_q + 1'b1;
                    mem_win_d = OUT_VOID;
                    mem_mv_d  = MV_NONE;
                    counted   = 1'b1;
                end
                default: ;
            endcase
        end

        // End check on post-update counts; played is widened so the sum cannot wrap.
        played_n = {2'b00, vp_d} + {2'b00, vs_d} + {2'b00, pa_d};
        diff_n   = (vp_d >= vs_d) ? (vp_d - vs_d) : (vs_d - vp_d);
        if (counted &&
            ((played_n == {2'b00, target_q}) ||
             ((played_n >= (CNT_W+2)'(MIN_ROUNDS)) && (diff_n >= CNT_W'(MARGIN))))) begin
            fine_d    = 1'b1;
            state_d   = DONE;
            partita_d = (vp_d > vs_d) ? 2'b01 : ((vs_d > vp_d) ? 2'b10 : 2'b11);
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            target_q  <= '0;
            vp_q      <= '0;
            vs_q      <= '0;
            pa_q      <= '0;
            manche_q  <= OUT_VOID;
            mv_q      <= 1'b0;
            partita_q <= '0;
            fine_q    <= 1'b0;
            mem_win_q <= OUT_VOID;
            mem_mv_q  <= MV_NONE;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            vp_q      <= vp_d;
            vs_q      <= vs_d;
            pa_q      <= pa_d;
            manche_q  <= manche_d;
            mv_q      <= mv_d;
            partita_q <= partita_d;
            fine_q    <= fine_d;
            mem_win_q <= mem_win_d;
            mem_mv_q  <= mem_mv_d;
        end
    end

    assign MANCHE        = manche_q;
    assign MANCHE_VALID  = mv_q;
    assign VINTE_PRIMO   = vp_q;
    assign VINTE_SECONDO = vs_q;
    assign PAREGGI       = pa_q;
    assign BUSY          = (state_q == PLAY);
    assign FINE_CONTO    = fine_q;
    assign PARTITA       = partita_q;

endmodule

// File: tb/tb_morra_referee_param.sv
// Directed bench for morra_referee_param with a round-result scoreboard.
module tb_morra_referee_param;

    localparam int unsigned CFG_W = 4;
    localparam int unsigned CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             START;
    logic [CFG_W-1:0] CONFIG;
    logic             MOVE_VALID;
    logic [1:0]       PRIMO;
    logic [1:0]       SECONDO;
    logic [1:0]       MANCHE;
    logic             MANCHE_VALID;
    logic [CNT_W-1:0] VINTE_PRIMO;
    logic [CNT_W-1:0] VINTE_SECONDO;
    logic [CNT_W-1:0] PAREGGI;
    logic             BUSY;
    logic             FINE_CONTO;
    logic [1:0]       PARTITA;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [1:0]  exp_q[$];

    morra_referee_param #(
        .CFG_W      (CFG_W),
        .BASE_ROUNDS(4),
        .CNT_W      (CNT_W),
        .MIN_ROUNDS (4),
        .MARGIN     (2),
        .NO_REPEAT  (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .START        (START),
        .CONFIG       (CONFIG),
        .MOVE_VALID   (MOVE_VALID),
        .PRIMO        (PRIMO),
        .SECONDO      (SECONDO),
        .MANCHE       (MANCHE),
        .MANCHE_VALID (MANCHE_VALID),
        .VINTE_PRIMO  (VINTE_PRIMO),
        .VINTE_SECONDO(VINTE_SECONDO),
        .PAREGGI      (PAREGGI),
        .BUSY         (BUSY),
        .FINE_CONTO   (FINE_CONTO),
        .PARTITA      (PARTITA)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_scores(input string tag, input int vp, input int vs, input int pa);
        chk({tag, "_vp"}, 32'(VINTE_PRIMO),   32'(vp));
        chk({tag, "_vs"}, 32'(VINTE_SECONDO), 32'(vs));
        chk({tag, "_pa"}, 32'(PAREGGI),       32'(pa));
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_manche"}, 32'(MANCHE),       32'd0);
        chk({tag, "_mv"},     32'(MANCHE_VALID), 32'd0);
        chk_scores(tag, 0, 0, 0);
        chk({tag, "_busy"},   32'(BUSY),         32'd0);
        chk({tag, "_fine"},   32'(FINE_CONTO),   32'd0);
        chk({tag, "_part"},   32'(PARTITA),      32'd0);
    endtask

    task automatic do_start(input logic [CFG_W-1:0] cfg);
        @(negedge clk);
        START  = 1'b1;
        CONFIG = cfg;
        @(negedge clk);
        START  = 1'b0;
    endtask

    // One judged round: the expected result is queued on drive and popped when MANCHE_VALID is due.
    task automatic play(input string tag, input logic [1:0] p1, input logic [1:0] p2,
                        input logic [1:0] exp);
        logic [1:0] e;
        @(negedge clk);
        PRIMO      = p1;
        SECONDO    = p2;
        MOVE_VALID = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        MOVE_VALID = 1'b0;
        chk({tag, "_valid"}, 32'(MANCHE_VALID), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_manche"}, 32'(MANCHE), 32'(e));
        end
    endtask

    // A move the DUT must ignore (IDLE/DONE): no pulse expected.
    task automatic ignored_move(input string tag, input logic [1:0] p1, input logic [1:0] p2);
        @(negedge clk);
        PRIMO      = p1;
        SECONDO    = p2;
        MOVE_VALID = 1'b1;
        @(negedge clk);
        MOVE_VALID = 1'b0;
        chk({tag, "_novalid"}, 32'(MANCHE_VALID), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        START      = 1'b0;
        CONFIG     = '0;
        MOVE_VALID = 1'b1;
        PRIMO      = 2'b01;
        SECONDO    = 2'b11;

        // 1: reset for two cycles with moves presented, then a move in IDLE
        repeat (2) @(negedge clk);
        chk_cleared("rst");
        rst_n      = 1'b1;
        MOVE_VALID = 1'b0;
        ignored_move("idle", 2'b01, 2'b11);
        chk_cleared("idle");

        // 2: CONFIG=3, P2 wins four straight -> early end on margin
        do_start(4'd3);
        chk("t2_busy", 32'(BUSY), 32'd1);
        play("t2_r1", 2'b11, 2'b01, 2'b10);
        play("t2_r2", 2'b10, 2'b11, 2'b10);
        play("t2_r3", 2'b01, 2'b10, 2'b10);
        chk("t2_r3_fine", 32'(FINE_CONTO), 32'd0);
        play("t2_r4", 2'b11, 2'b01, 2'b10);
        chk("t2_fine", 32'(FINE_CONTO), 32'd1);
        chk("t2_part", 32'(PARTITA), 32'd2);
        chk("t2_busy_end", 32'(BUSY), 32'd0);
        chk_scores("t2", 0, 4, 0);
        ignored_move("t2_done", 2'b01, 2'b11);
        chk_scores("t2_hold", 0, 4, 0);
        chk("t2_fine_hold", 32'(FINE_CONTO), 32'd1);

        // 3: repeat rule, then a draw clears the memory
        do_start(4'd3);
        chk_scores("t3_start", 0, 0, 0);
        chk("t3_fine_clr", 32'(FINE_CONTO), 32'd0);
        play("t3_r1", 2'b01, 2'b11, 2'b01);
        play("t3_rep", 2'b01, 2'b11, 2'b00);
        chk_scores("t3_rep", 1, 0, 0);
        play("t3_r2", 2'b10, 2'b01, 2'b01);
        chk_scores("t3_r2", 2, 0, 0);
        play("t3_draw", 2'b01, 2'b01, 2'b11);
        play("t3_r3", 2'b10, 2'b01, 2'b01);
        chk_scores("t3_r3", 3, 0, 1);
        chk("t3_fine", 32'(FINE_CONTO), 32'd1);
        chk("t3_part", 32'(PARTITA), 32'd1);

        // 4: CONFIG=0, void round not counted, four draws reach the length
        do_start(4'd0);
        play("t4_void", 2'b00, 2'b00, 2'b00);
        chk_scores("t4_void", 0, 0, 0);
        for (int i = 0; i < 4; i++) play("t4_draw", 2'b10, 2'b10, 2'b11);
        chk_scores("t4", 0, 0, 4);
        chk("t4_fine", 32'(FINE_CONTO), 32'd1);
        chk("t4_part", 32'(PARTITA), 32'd3);

        // 4b: forfeits award the round to the player who moved
        do_start(4'd0);
        play("t4b_f2", 2'b00, 2'b10, 2'b10);
        play("t4b_f1", 2'b01, 2'b00, 2'b01);
        chk_scores("t4b", 1, 1, 0);

        // 5: START mid-match with a move in the same cycle
        do_start(4'd5);
        play("t5_pre", 2'b01, 2'b11, 2'b01);
        @(negedge clk);
        START      = 1'b1;
        CONFIG     = 4'd5;
        MOVE_VALID = 1'b1;
        PRIMO      = 2'b11;
        SECONDO    = 2'b01;
        @(negedge clk);
        START      = 1'b0;
        MOVE_VALID = 1'b0;
        chk("t5_novalid", 32'(MANCHE_VALID), 32'd0);
        chk("t5_manche", 32'(MANCHE), 32'd0);
        chk("t5_busy", 32'(BUSY), 32'd1);
        chk_scores("t5", 0, 0, 0);
        for (int i = 0; i < 8; i++) play("t5_draw", 2'b11, 2'b11, 2'b11);
        chk("t5_fine8", 32'(FINE_CONTO), 32'd0);
        play("t5_draw9", 2'b11, 2'b11, 2'b11);
        chk("t5_fine9", 32'(FINE_CONTO), 32'd1);
        chk("t5_part", 32'(PARTITA), 32'd3);

        // 6: reset mid-match, then moves ignored until START
        do_start(4'd2);
        play("t6_pre", 2'b11, 2'b01, 2'b10);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_cleared("t6_rst");
        ignored_move("t6_idle", 2'b10, 2'b01);
        chk_cleared("t6_idle");
        do_start(4'd2);
        play("t6_post", 2'b10, 2'b01, 2'b01);
        chk_scores("t6_post", 1, 0, 0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
